alu_mul_seq: RTL
================

Name: alu_mul_seq

Overview:
- Multi-cycle 16x16 unsigned multiply sequencer built on the shared 16-bit ALU.
- Has no multiplier of its own. It drives the ALU operand, opcode and flag-enable inputs one operation per cycle (ADD / SHL / SHR) and captures the ALU result and carry flag.
- Produces the low 16 bits of the product plus a sticky overflow flag.
- Sits between the CPU execute stage (start/done handshake) and the ALU port mux.

Parameters:
- EARLY_EXIT, 1: 1 = finish when the remaining multiplier reaches 0; 0 = always run 16 iterations (fixed latency).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising clk.
- start  in  1  request; sampled only in IDLE.
- op_a  in  16  multiplicand, captured when start is accepted.
- op_b  in  16  multiplier, captured when start is accepted.
- busy  out  1  high from the cycle after acceptance until DONE is left.
- done  out  1  single-cycle pulse; result/ovf valid.
- result  out  16  low 16 bits of op_a*op_b; held until the next accepted start.
- ovf  out  1  high if the true product exceeds 0xFFFF; held like result.
- alu_a  out  16  ALU operand A.
- alu_b  out  16  ALU operand B.
- alu_op  out  3  ALU opcode: 000 add, 010 shl, 011 shr.
- alu_en_flags  out  1  ALU flag update enable.
- alu_s  in  16  combinational ALU result.
- alu_flags  in  4  ALU flag register, updated on falling clk edge; bit2 = carry.

Behaviour:
- Reset (rst=0 at rising edge): state=IDLE, busy=0, done=0, result=0, ovf=0, internal acc/mcand/mplier=0. Applies at any time; an in-flight operation is aborted with no done pulse.
- States: IDLE, ADD, SHL, SHR, DONE. Internal regs: acc, mcand, mplier (16b each), ovf_r.
- IDLE:
  - ALU outputs idle (alu_a=alu_b=0, alu_op=000, alu_en_flags=0).
  - On start=1: acc<=0, mcand<=op_a, mplier<=op_b, ovf_r<=0.
  - Next state: DONE if op_b==0 (and EARLY_EXIT=1); else ADD if op_b[0]=1; else SHL.
- ADD:
  - Drives alu_a=acc, alu_b=mcand, alu_op=000, alu_en_flags=1.
  - At the rising edge: acc<=alu_s; if alu_flags[2]=1 then ovf_r<=1. Next state: SHL.
- SHL:
  - Drives alu_a=mcand, alu_b=1, alu_op=010, alu_en_flags=1.
  - At the rising edge: mcand<=alu_s; if alu_flags[2]=1 and mplier[15:1]!=0 then ovf_r<=1. Next state: SHR.
- SHR:
  - Drives alu_a=mplier, alu_b=1, alu_op=011, alu_en_flags=0.
  - At the rising edge: mplier<=alu_s; iteration count +1.
  - Next state: DONE if (EARLY_EXIT=1 and alu_s==0) or 16 iterations done; else ADD if alu_s[0]=1; else SHL.
- Flag sampling: the ALU flags update on the falling edge inside the enabled cycle. The controller samples alu_flags[2] at the closing rising edge of that same cycle.
- DONE:
  - ALU outputs idle; done=1 for exactly this cycle; busy=1.
  - result<=acc, ovf<=ovf_r. Next state: IDLE.
  - result/ovf become visible the cycle after done and are stable until the next accepted start.
  - Consumers take result one cycle after done, or use the registered hold.
- start while busy (any non-IDLE state): ignored, no queueing.
- start in the DONE cycle: ignored. The earliest re-accept is the IDLE cycle after DONE.
- Latency, EARLY_EXIT=1:
  - k = position of the highest set bit of op_b plus 1; p = popcount(op_b).
  - Op cycles N = p + 2k. done is asserted N+1 cycles after the acceptance edge.
  - op_b=0 gives N=0: done in the cycle right after acceptance.
- Latency, EARLY_EXIT=0: k=16, N = p + 32.
- All arithmetic is unsigned and modulo 2^16. The ALU is the only adder/shifter used.

Test Plan:
- Reset mid-op: start a=3, b=0xFFFF; pull rst low during SHL of iteration 4 -> next cycle state IDLE, busy=0, done=0, result=0, ovf=0; no done pulse ever follows.
- Basic: a=3, b=5 -> ALU op sequence ADD,SHL,SHR,SHL,SHR,ADD,SHL,SHR (8 cycles); done on the 9th cycle after acceptance; result=0x000F, ovf=0.
- Zero multiplier: a=0x1234, b=0 -> no ALU ops, alu_en_flags never 1, done 1 cycle after acceptance, result=0, ovf=0.
- Overflow via shift: a=0x8000, b=3 -> result=0x8000, ovf=1. Then a=0xFFFF, b=0xFFFF -> result=0x0001, ovf=1, done after 48+1 cycles.
- Long no-overflow: a=0, b=0x8000 -> 33 op cycles (1 ADD), result=0, ovf=0. With EARLY_EXIT=0, a=2, b=1 -> 33 op cycles, result=2, ovf=0.
- Handshake: pulse start again every cycle while busy with different operands -> ignored, result matches the first operands. Hold start=1 continuously -> back-to-back ops, each re-accepted in the IDLE cycle after DONE.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Shift-and-add 16x16 unsigned multiplier that borrows the shared ALU one op per cycle.
// Keeps the low 16 product bits and a sticky overflow flag.
module alu_mul_seq #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        ovf,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op,
    output logic        alu_en_flags,
    input  logic [15:0] alu_s,
    input  logic [3:0]  alu_flags
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_SHL  = 3'd2,
        S_SHR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;

    state_t      state_r;
    logic [15:0] acc_r;
    logic [15:0] mcand_r;
    logic [15:0] mplier_r;
    logic        ovf_r;
    logic [4:0]  iter_r;

    state_t      nxt_state_s;
    logic [15:0] nxt_acc_s;
    logic [15:0] nxt_mcand_s;
    logic [15:0] nxt_mplier_s;
    logic        nxt_ovf_s;
    logic [4:0]  nxt_iter_s;

    logic [15:0] drv_a_s;
    logic [15:0] drv_b_s;
    logic [2:0]  drv_op_s;
    logic        drv_en_s;

    logic        carry_s;
    logic        unused_flags_s;

    assign carry_s        = alu_flags[2];
    assign unused_flags_s = ^{alu_flags[3], alu_flags[1:0]};

    // Choose the next operation from the remaining multiplier bits.
    function automatic state_t dispatch(input logic [15:0] m);
        if ((EARLY_EXIT == 1'b1) && (m == 16'd0)) begin
            return S_DONE;
        end else if (m[0] == 1'b1) begin
            return S_ADD;
        end else begin
            return S_SHL;
        end
    endfunction

    // Next-state and datapath update from the current state and ALU response.
    always_comb begin
        nxt_state_s  = state_r;
        nxt_acc_s    = acc_r;
        nxt_mcand_s  = mcand_r;
        nxt_mplier_s = mplier_r;
        nxt_ovf_s    = ovf_r;
        nxt_iter_s   = iter_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    nxt_acc_s    = 16'd0;
                    nxt_mcand_s  = op_a;
                    nxt_mplier_s = op_b;
                    nxt_ovf_s    = 1'b0;
                    nxt_iter_s   = 5'd0;
                    nxt_state_s  = dispatch(op_b);
                end else begin
                    nxt_state_s = S_IDLE;
                end
            end
            S_ADD: begin
                nxt_acc_s = alu_s;
                if (carry_s) begin
                    nxt_ovf_s = 1'b1;
                end else begin
                    nxt_ovf_s = ovf_r;
                end
                nxt_state_s = S_SHL;
            end
            S_SHL: begin
                nxt_mcand_s = alu_s;
                // A bit lost off the top only matters if a later multiplier bit will add it.
                if (carry_s && (mplier_r[15:1] != 15'd0)) begin
                    nxt_ovf_s = 1'b1;
                end else begin
                    nxt_ovf_s = ovf_r;
                end
                nxt_state_s = S_SHR;
            end
            S_SHR: begin
                nxt_mplier_s = alu_s;
                nxt_iter_s   = iter_r + 5'd1;
                if (iter_r == 5'd15) begin
                    nxt_state_s = S_DONE;
                end else begin
                    nxt_state_s = dispatch(alu_s);
                end
            end
            S_DONE: begin
                nxt_state_s = S_IDLE;
            end
            default: begin
                nxt_state_s = S_IDLE;
            end
        endcase
    end

    // ALU drive for the state being entered, so the port registers line up with it.
    always_comb begin
        drv_a_s  = 16'd0;
        drv_b_s  = 16'd0;
        drv_op_s = OP_ADD;
        drv_en_s = 1'b0;
        case (nxt_state_s)
            S_ADD: begin
                drv_a_s  = nxt_acc_s;
                drv_b_s  = nxt_mcand_s;
                drv_op_s = OP_ADD;
                drv_en_s = 1'b1;
            end
            S_SHL: begin
                drv_a_s  = nxt_mcand_s;
                drv_b_s  = 16'd1;
                drv_op_s = OP_SHL;
                drv_en_s = 1'b1;
            end
            S_SHR: begin
                drv_a_s  = nxt_mplier_s;
                drv_b_s  = 16'd1;
                drv_op_s = OP_SHR;
                drv_en_s = 1'b0;
            end
            default: begin
                drv_a_s  = 16'd0;
                drv_b_s  = 16'd0;
                drv_op_s = OP_ADD;
                drv_en_s = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            acc_r        <= 16'd0;
            mcand_r      <= 16'd0;
            mplier_r     <= 16'd0;
            ovf_r        <= 1'b0;
            iter_r       <= 5'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= 16'd0;
            ovf          <= 1'b0;
            alu_a        <= 16'd0;
            alu_b        <= 16'd0;
            alu_op       <= OP_ADD;
            alu_en_flags <= 1'b0;
        end else begin
            state_r      <= nxt_state_s;
            acc_r        <= nxt_acc_s;
            mcand_r      <= nxt_mcand_s;
            mplier_r     <= nxt_mplier_s;
            ovf_r        <= nxt_ovf_s;
            iter_r       <= nxt_iter_s;
            busy         <= (nxt_state_s != S_IDLE);
            done         <= (nxt_state_s == S_DONE);
            alu_a        <= drv_a_s;
            alu_b        <= drv_b_s;
            alu_op       <= drv_op_s;
            alu_en_flags <= drv_en_s;
            if (state_r == S_DONE) begin
                result <= acc_r;
                ovf    <= ovf_r;
            end else begin
                result <= result;
                ovf    <= ovf;
            end
        end
    end

endmodule
